// File: rtl/fir_out_packer.sv
// fir_out_packer: scales and saturates signed filter samples to OUT_WIDTH
// lanes, packs LANES of them into one BUS_WIDTH word (early close on s_last)
// and queues closed words in a 2-entry output FIFO.
// Optional feature: define FIR_OUT_ROUND_EN to round half-up before the
// shift; otherwise the shift truncates toward negative infinity.
module fir_out_packer #(
    parameter int IN_WIDTH  = 20,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 8,
    parameter int BUS_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    input  logic [IN_WIDTH-1:0]    s_data,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic                   m_valid,
    output logic [BUS_WIDTH-1:0]   m_data,
    output logic [BUS_WIDTH/OUT_WIDTH-1:0] m_keep,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic [15:0]            sat_count
);
    localparam int LANES = BUS_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int EXT_W = IN_WIDTH + 1;

    // Saturation bounds expressed in the widened scaling domain.
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    logic                   accept;
    logic                   close;
    logic                   push;
    logic                   pop;
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] y;
    logic                   over;
    logic                   under;
    logic [OUT_WIDTH-1:0]   lane_val;

    logic [CNT_W-1:0]       lane_cnt_reg;
    logic [BUS_WIDTH-1:0]   word_reg;
    logic [BUS_WIDTH-1:0]   word_next;
    logic [LANES-1:0]       keep_reg;
    logic [LANES-1:0]       keep_next;

    logic [BUS_WIDTH-1:0]   data_mem [2];
    logic [LANES-1:0]       keep_mem [2];
    logic                   last_mem [2];
    logic                   wr_ptr_reg;
    logic                   rd_ptr_reg;
    logic [1:0]             count_reg;
    logic [15:0]            sat_count_reg;

    // Sign-extend one bit so the rounding add can never wrap.
`ifdef FIR_OUT_ROUND_EN
    localparam logic [EXT_W-1:0] ROUND_ADD = EXT_W'(1) << (SHIFT - 1);
    assign ext = $signed({s_data[IN_WIDTH-1], s_data} + ROUND_ADD);
`else
    assign ext = $signed({s_data[IN_WIDTH-1], s_data});
`endif

    assign y     = ext >>> SHIFT;
    assign over  = (y > SAT_MAX);
    assign under = (y < SAT_MIN);

    // Clip to the lane range, otherwise keep the low OUT_WIDTH bits.
    always_comb begin
        lane_val = y[OUT_WIDTH-1:0];
        if (over) begin
            lane_val = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (under) begin
            lane_val = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
    end

    assign s_ready = (count_reg != 2'd2);
    assign accept  = s_valid && s_ready;
    assign close   = accept && (s_last || (lane_cnt_reg == CNT_W'(LANES - 1)));
    assign push    = close;
    assign m_valid = (count_reg != 2'd0);
    assign pop     = m_valid && m_ready;

    // Per-lane insertion of the scaled sample into the word being built.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic hit;
            assign hit = accept && (lane_cnt_reg == CNT_W'(gi));
            assign word_next[gi*OUT_WIDTH +: OUT_WIDTH] =
                hit ? lane_val : word_reg[gi*OUT_WIDTH +: OUT_WIDTH];
            assign keep_next[gi] = hit | keep_reg[gi];
        end
    endgenerate

    // Partial-word accumulator; cleared whenever a word closes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_cnt_reg <= '0;
            word_reg     <= '0;
            keep_reg     <= '0;
        end else if (accept) begin
            if (close) begin
                lane_cnt_reg <= '0;
                word_reg     <= '0;
                keep_reg     <= '0;
            end else begin
                lane_cnt_reg <= lane_cnt_reg + 1'b1;
                word_reg     <= word_next;
                keep_reg     <= keep_next;
            end
        end
    end

    // Two-entry output FIFO; simultaneous push and pop keeps the occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_mem[i] <= '0;
                keep_mem[i] <= '0;
                last_mem[i] <= 1'b0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                data_mem[wr_ptr_reg] <= word_next;
                keep_mem[wr_ptr_reg] <= keep_next;
                last_mem[wr_ptr_reg] <= s_last;
                wr_ptr_reg           <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 2'd1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 2'd1;
            end
        end
    end

    // Clip counter, sticky at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_count_reg <= '0;
        end else if (accept && (over || under) && (sat_count_reg != 16'hFFFF)) begin
            sat_count_reg <= sat_count_reg + 16'd1;
        end
    end

    assign m_data    = data_mem[rd_ptr_reg];
    assign m_keep    = keep_mem[rd_ptr_reg];
    assign m_last    = last_mem[rd_ptr_reg];
    assign sat_count = sat_count_reg;

endmodule

// File: tb/tb_fir_out_packer.sv
// Directed testbench for fir_out_packer (default parameters).
// Rounding expectations follow FIR_OUT_ROUND_EN when it is defined.
module tb_fir_out_packer;
    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic [19:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        m_ready;
    logic [15:0] sat_count;

    int n_cmp;
    int n_fail;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;
    word_t words[$];

`ifdef FIR_OUT_ROUND_EN
    localparam logic [31:0] EXP_POS = 32'h0000_0002;
    localparam logic [31:0] EXP_NEG = 32'h0000_00FF;
`else
    localparam logic [31:0] EXP_POS = 32'h0000_0001;
    localparam logic [31:0] EXP_NEG = 32'h0000_00FE;
`endif

    fir_out_packer #(
        .IN_WIDTH (20),
        .OUT_WIDTH(8),
        .SHIFT    (8),
        .BUS_WIDTH(32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_keep   (m_keep),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .sat_count(sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every word handed over downstream (inputs change only after posedge).
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            words.push_back({m_data, m_keep, m_last});
            $display("word out: data=%08h keep=%h last=%0d", m_data, m_keep, m_last);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample until accepted (bounded).
    task automatic send(input int value, input logic last);
        logic acc;
        acc = 1'b0;
        s_valid = 1'b1;
        s_data  = 20'(value);
        s_last  = last;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = s_ready;
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_timeout: sample %0d not accepted, required accept within 50 cycles", value);
        end else begin
            $display("sample in: %0d last=%0d", value, last);
        end
    endtask

    // Wait (bounded) for the next recorded output word.
    task automatic get_word(output word_t w);
        int i;
        i = 0;
        while (words.size() == 0 && i < 30) begin
            step();
            i++;
        end
        n_cmp++;
        if (words.size() == 0) begin
            n_fail++;
            $display("FAIL word_timeout: no word seen, required one within 30 cycles");
            w = '0;
        end else begin
            w = words.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_cmp += 5;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %0b want 0", m_valid); end
        if (m_data !== 32'h0) begin n_fail++; $display("FAIL rst_m_data: got %08h want 00000000", m_data); end
        if (m_keep !== 4'h0) begin n_fail++; $display("FAIL rst_m_keep: got %h want 0", m_keep); end
        if (m_last !== 1'b0) begin n_fail++; $display("FAIL rst_m_last: got %0b want 0", m_last); end
        if (sat_count !== 16'h0) begin n_fail++; $display("FAIL rst_sat_count: got %h want 0000", sat_count); end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_s_ready: got %0b want 1", s_ready); end
    endtask

    task automatic test_rounding();
        word_t w;
        m_ready = 1'b1;
        send(384, 1'b1);
        get_word(w);
        n_cmp += 3;
        if (w.d !== EXP_POS) begin n_fail++; $display("FAIL round_pos_data: got %08h want %08h", w.d, EXP_POS); end
        if (w.k !== 4'h1) begin n_fail++; $display("FAIL round_pos_keep: got %h want 1", w.k); end
        if (w.l !== 1'b1) begin n_fail++; $display("FAIL round_pos_last: got %0b want 1", w.l); end
        send(-384, 1'b1);
        get_word(w);
        n_cmp += 2;
        if (w.d !== EXP_NEG) begin n_fail++; $display("FAIL round_neg_data: got %08h want %08h", w.d, EXP_NEG); end
        if (sat_count !== 16'd0) begin n_fail++; $display("FAIL round_no_clip: got %0d want 0", sat_count); end
    endtask

    task automatic test_saturation();
        word_t w;
        send(32'h7FFFF, 1'b0);
        send(-524288, 1'b1);
        get_word(w);
        n_cmp += 3;
        if (w.d !== 32'h0000_807F) begin n_fail++; $display("FAIL sat_data: got %08h want 0000807f", w.d); end
        if (w.k !== 4'h3) begin n_fail++; $display("FAIL sat_keep: got %h want 3", w.k); end
        if (sat_count !== 16'd2) begin n_fail++; $display("FAIL sat_count: got %0d want 2", sat_count); end
    endtask

    task automatic test_pack();
        word_t w;
        send(256, 1'b0);
        send(512, 1'b0);
        send(768, 1'b0);
        n_cmp++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL pack_early_valid: got %0b want 0", m_valid); end
        send(1024, 1'b0);
        n_cmp++;
        if (m_valid !== 1'b1) begin n_fail++; $display("FAIL pack_latency: got %0b want 1", m_valid); end
        get_word(w);
        n_cmp += 3;
        if (w.d !== 32'h0403_0201) begin n_fail++; $display("FAIL pack_data: got %08h want 04030201", w.d); end
        if (w.k !== 4'hF) begin n_fail++; $display("FAIL pack_keep: got %h want f", w.k); end
        if (w.l !== 1'b0) begin n_fail++; $display("FAIL pack_last: got %0b want 0", w.l); end
    endtask

    task automatic test_partial();
        word_t w;
        send(256, 1'b0);
        send(512, 1'b1);
        get_word(w);
        n_cmp += 3;
        if (w.d !== 32'h0000_0201) begin n_fail++; $display("FAIL partial_data: got %08h want 00000201", w.d); end
        if (w.k !== 4'h3) begin n_fail++; $display("FAIL partial_keep: got %h want 3", w.k); end
        if (w.l !== 1'b1) begin n_fail++; $display("FAIL partial_last: got %0b want 1", w.l); end
        send(768, 1'b1);
        get_word(w);
        n_cmp += 2;
        if (w.d !== 32'h0000_0003) begin n_fail++; $display("FAIL partial_next_data: got %08h want 00000003", w.d); end
        if (w.k !== 4'h1) begin n_fail++; $display("FAIL partial_next_keep: got %h want 1", w.k); end
    endtask

    task automatic test_back_to_back();
        word_t w;
        logic a;
        logic [31:0] held;
        int acc;
        acc = 0;
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_last  = 1'b0;
        s_data  = 20'(256);
        for (int c = 0; c < 20 && acc < 12; c++) begin
            @(negedge clk);
            a = s_ready;
            step();
            if (a) begin
                acc++;
                s_data = 20'((acc + 1) * 256);
            end
        end
        s_valid = 1'b0;
        $display("backpressure: %0d of 12 accepted", acc);
        n_cmp += 3;
        if (acc !== 8) begin n_fail++; $display("FAIL bp_accepted: got %0d want 8", acc); end
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready: got %0b want 0", s_ready); end
        if (words.size() !== 0) begin n_fail++; $display("FAIL bp_no_pop: got %0d words want 0", words.size()); end
        held = m_data;
        step();
        step();
        step();
        n_cmp += 2;
        if (m_data !== 32'h0403_0201) begin n_fail++; $display("FAIL bp_head: got %08h want 04030201", m_data); end
        if (m_data !== held || m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stable: got %08h valid=%0b want %08h valid=1", m_data, m_valid, held);
        end
        m_ready = 1'b1;
        get_word(w);
        n_cmp++;
        if (w.d !== 32'h0403_0201) begin n_fail++; $display("FAIL bp_word0: got %08h want 04030201", w.d); end
        get_word(w);
        n_cmp++;
        if (w.d !== 32'h0807_0605) begin n_fail++; $display("FAIL bp_word1: got %08h want 08070605", w.d); end
        step();
        n_cmp++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %0b want 0", m_valid); end
    endtask

    task automatic test_reset_midframe();
        word_t w;
        m_ready = 1'b1;
        send(32'h7FFFF, 1'b0);
        send(512, 1'b0);
        send(768, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp += 2;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %0b want 0", m_valid); end
        if (sat_count !== 16'd0) begin n_fail++; $display("FAIL mid_rst_sat: got %0d want 0", sat_count); end
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (words.size() !== 0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_no_word: got %0d words valid=%0b want 0 words valid=0", words.size(), m_valid);
        end
        send(5 * 256, 1'b0);
        send(6 * 256, 1'b0);
        send(7 * 256, 1'b0);
        send(8 * 256, 1'b0);
        get_word(w);
        n_cmp += 2;
        if (w.d !== 32'h0807_0605) begin n_fail++; $display("FAIL mid_rst_fresh: got %08h want 08070605", w.d); end
        if (w.k !== 4'hF) begin n_fail++; $display("FAIL mid_rst_keep: got %h want f", w.k); end
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_rounding();
        test_saturation();
        test_pack();
        test_partial();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
